seg7_scan_ctrl: RTL
===================

Name: seg7_scan_ctrl

Overview:
Parametrised multiplexed seven-segment display controller driving NUM_DIGITS common-anode/cathode digits from a packed hex value.
- Adds programmable scan rate, per-digit blanking and decimal points, anti-ghosting blank gap, and tear-free double-buffered updates.
- Sits between the game/score logic and the board's segment/position pins.
- Supersedes fixed two-digit scanners.

Parameters:
NUM_DIGITS, 8, number of digits scanned (2..16)
SCAN_DIV, 1000, clk cycles each digit is selected (>= 2)
BLANK_CYC, 2, cycles at start of each digit slot with all positions off (0 <= BLANK_CYC < SCAN_DIV)
SEG_ACTIVE_LOW, 0, 1 inverts seg_out and dp_out
POS_ACTIVE_LOW, 0, 1 inverts data_pos

Ports:
clk  in  1  system clock
resetn  in  1  reset
enable  in  1  scan enable
load  in  1  single-cycle request to capture new display content
digits_in  in  4*NUM_DIGITS  hex nibbles; digit k = bits [4k+3:4k]
blank_in  in  NUM_DIGITS  1 = digit k dark
dp_in  in  NUM_DIGITS  1 = decimal point of digit k lit
seg_out  out  7  segments {a,b,c,d,e,f,g}, a = MSB
dp_out  out  1  decimal point
data_pos  out  NUM_DIGITS  one-hot digit select; bit k = digit k
scan_idx  out  clog2(NUM_DIGITS)  digit currently selected
frame_done  out  1  one-cycle pulse per completed scan frame

Behaviour:
- Reset: resetn is asynchronous, active-low; clock is clk. During reset:
  - Prescaler cnt = 0, scan_idx = 0.
  - Pending and active buffers = 0, pending_valid = 0.
  - seg_out, dp_out and data_pos at their inactive level (all 0 before polarity inversion).
  - frame_done = 0.
- Prescaler:
  - cnt counts 0..SCAN_DIV-1 while enable = 1.
  - tick = (cnt == SCAN_DIV-1); on tick, cnt -> 0 and scan_idx increments, wrapping NUM_DIGITS-1 -> 0.
- Frame wrap: frame boundary = tick with scan_idx == NUM_DIGITS-1.
  - frame_done is registered and pulses high the cycle after the boundary.
- Double buffering:
  - On load, digits_in, blank_in and dp_in are captured into the pending buffer and pending_valid is set.
  - At a frame boundary with pending_valid = 1, pending is copied to active and pending_valid is cleared.
  - Load coincident with a frame boundary: the new inputs go directly to active and pending_valid stays 0.
  - Multiple loads within one frame: the last one wins.
  - Active content never changes mid-frame.
- Outputs are registered, one-cycle latency from (cnt, scan_idx, active, enable):
  - data_pos = one-hot(scan_idx) when cnt >= BLANK_CYC; otherwise all inactive (anti-ghost gap).
  - seg_out = hex decode of active nibble[scan_idx], or all-off if blank[scan_idx].
  - dp_out = dp[scan_idx] & ~blank[scan_idx].
  - Polarity parameters are applied last.
- Hex decode (a..g):
  - 0 1111110, 1 0110000, 2 1101101, 3 1111001
  - 4 0110011, 5 1011011, 6 1011111, 7 1110000
  - 8 1111111, 9 1111011, A 1110111, b 0011111
  - C 1001110, d 0111101, E 1001111, F 1000111
- enable = 0:
  - cnt and scan_idx hold; all outputs inactive from the next cycle.
  - Loads are still accepted into pending; no buffer swap occurs.
  - On re-enable, scanning resumes from the held cnt and scan_idx.
- Reset mid-scan: asynchronous return to the reset state; pending data is discarded.
- No combinational path from any input to any output.

Test Plan:
Bench configuration for all scenarios: NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, active-high polarity.
1. Reset then enable=1, no load -> data_pos cycles 0001,0010,0100,1000 with one all-zero cycle at the start of each 4-cycle slot; seg_out=1111110 (digit 0 value); frame_done pulses every 16 cycles.
2. load with digits_in=16'h3A7F, blank_in=0, dp_in=4'b0010 mid-frame -> display unchanged until the frame boundary. Next frame: digit0 seg=1000111 (F), digit1=1110000 with dp_out=1, digit2=1110111, digit3=1111001.
3. blank_in=4'b1000 loaded -> during the digit3 slot seg_out=0000000 and dp_out=0, while data_pos bit3 is still asserted for 3 cycles.
4. Load asserted exactly on the frame-boundary tick, plus a second load 2 cycles later with different data -> first data shown in the next frame; second data shown in the frame after.
5. enable dropped during digit2 at cnt=2 for 10 cycles -> outputs inactive from the next cycle; on re-enable digit2 resumes and frame_done timing shifts by exactly 10 cycles.
6. resetn asserted mid-frame with pending_valid=1 -> outputs inactive immediately (asynchronous); after release, scan_idx=0 and display shows all zeros, with no pending data applied.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scanner with a programmable slot length and an anti-ghost gap.
// Display content is double-buffered, so a new value only takes effect at a frame boundary.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYC      = 2,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int POS_ACTIVE_LOW = 0
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          enable,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic [NUM_DIGITS-1:0]         blank_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  output logic [6:0]                    seg_out,
  output logic                          dp_out,
  output logic [NUM_DIGITS-1:0]         data_pos,
  output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
  output logic                          frame_done
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
  localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] POS_OFF = {NUM_DIGITS{POS_ACTIVE_LOW != 0}};

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [NUM_DIGITS-1:0][3:0] pend_dig_q, pend_dig_d, act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0]      pend_blk_q, pend_blk_d, act_blk_q, act_blk_d;
  logic [NUM_DIGITS-1:0]      pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic                       pend_vld_q, pend_vld_d;

  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] pos_q, pos_d;
  logic                  fd_q, fd_d;

  logic                  tick, bnd;
  logic [NUM_DIGITS-1:0] onehot;
  logic [6:0]            seg_raw;
  logic                  dp_raw;
  logic [NUM_DIGITS-1:0] pos_raw;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_sel
    assign onehot[g] = (idx_q == IW'(g));
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1111110;  4'h1: hex7 = 7'b0110000;
      4'h2: hex7 = 7'b1101101;  4'h3: hex7 = 7'b1111001;
      4'h4: hex7 = 7'b0110011;  4'h5: hex7 = 7'b1011011;
      4'h6: hex7 = 7'b1011111;  4'h7: hex7 = 7'b1110000;
      4'h8: hex7 = 7'b1111111;  4'h9: hex7 = 7'b1111011;
      4'ha: hex7 = 7'b1110111;  4'hb: hex7 = 7'b0011111;
      4'hc: hex7 = 7'b1001110;  4'hd: hex7 = 7'b0111101;
      4'he: hex7 = 7'b1001111;  default: hex7 = 7'b1000111;
    endcase
  endfunction

  always_comb begin
    tick  = enable && (cnt_q == CW'(SCAN_DIV - 1));
    bnd   = tick && (idx_q == IW'(NUM_DIGITS - 1));
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (tick) begin
      cnt_d = '0;
      idx_d = bnd ? '0 : idx_q + 1'b1;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end

    pend_dig_d = pend_dig_q;
    pend_blk_d = pend_blk_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    act_dig_d  = act_dig_q;
    act_blk_d  = act_blk_q;
    act_dp_d   = act_dp_q;
    // A load on the boundary itself bypasses pending and supersedes any older pending data.
    if (bnd) begin
      pend_vld_d = 1'b0;
      if (load) begin
        act_dig_d = digits_in;
        act_blk_d = blank_in;
        act_dp_d  = dp_in;
      end else if (pend_vld_q) begin
        act_dig_d = pend_dig_q;
        act_blk_d = pend_blk_q;
        act_dp_d  = pend_dp_q;
      end
    end else if (load) begin
      pend_dig_d = digits_in;
      pend_blk_d = blank_in;
      pend_dp_d  = dp_in;
      pend_vld_d = 1'b1;
    end

    seg_raw = '0;
    dp_raw  = 1'b0;
    pos_raw = '0;
    if (enable) begin
      seg_raw = act_blk_q[idx_q] ? 7'b0 : hex7(act_dig_q[idx_q]);
      dp_raw  = act_dp_q[idx_q] & ~act_blk_q[idx_q];
      pos_raw = (cnt_q >= CW'(BLANK_CYC)) ? onehot : '0;
    end
    seg_d = seg_raw ^ SEG_OFF;
    dp_d  = dp_raw ^ DP_OFF;
    pos_d = pos_raw ^ POS_OFF;
    fd_d  = bnd;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_dig_q <= '0;
      pend_blk_q <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      act_dig_q  <= '0;
      act_blk_q  <= '0;
      act_dp_q   <= '0;
      seg_q      <= SEG_OFF;
      dp_q       <= DP_OFF;
      pos_q      <= POS_OFF;
      fd_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_dig_q <= pend_dig_d;
      pend_blk_q <= pend_blk_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      act_dig_q  <= act_dig_d;
      act_blk_q  <= act_blk_d;
      act_dp_q   <= act_dp_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      pos_q      <= pos_d;
      fd_q       <= fd_d;
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign data_pos   = pos_q;
  assign scan_idx   = idx_q;
  assign frame_done = fd_q;
endmodule
